intt_stage_router: RTL and testbench
====================================

# intt_stage_router

Parametrised, self-sequencing coefficient router between the INTT butterfly cores and the coefficient memories. An internal stage FSM tracks the transform stage, which replaces externally driven `log_m`/`log_t`. Each accepted beat is routed with a one-cycle registered latency, either back to memory (loop path) or, on the final stage, to the output path. Valid qualifiers and a done pulse are provided.

## Interface
- `LOG_N`, 12: log2 of transform length; must satisfy `LOG_N >= LOG_CORE_COUNT + 3`.
- `LOG_CORE_COUNT`, 5: log2 of core count C.
- `COEFF_W`, 30: coefficient width.
- `ADDR_W`, 9: memory address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a transform when idle.
- `in_valid`  in  1  beat on `in`/`address_in` valid this cycle.
- `address_in`  in  2×ADDR_W  addresses of the two read lanes.
- `in`  in  C×4×COEFF_W  four butterfly results per core.
- `loop`  out  C×2×(2·COEFF_W)  coefficient pairs written back; packed {hi, lo}.
- `address_loop`  out  2×ADDR_W  write-back addresses.
- `loop_valid`  out  1  loop beat valid.
- `out`  out  C×2×(2·COEFF_W)  final coefficient pairs.
- `address_out`  out  ADDR_W  final address.
- `out_valid`  out  1  out beat valid.
- `busy`  out  1  transform in progress.
- `done`  out  1  one-cycle pulse after the last beat is registered.

## Operation
- Constants: BEATS = 2^(LOG_N−LOG_CORE_COUNT−2) beats per stage; T_INTRA = LOG_N−LOG_CORE_COUNT−2.
- Stage counter s runs from 0 to LOG_N−1, with log_t = s.
- FSM states and phases:
  - IDLE.
  - FIRST: s = 0.
  - INTRA: 1 ≤ s ≤ T_INTRA.
  - INTER: T_INTRA < s ≤ LOG_N−2.
  - LAST: s = LOG_N−1.
- Beat counter b counts accepted beats (`in_valid`=1 while not IDLE). At b = BEATS−1 with an accepted beat, b wraps to 0 and s increments, which moves the phase per the ranges above. The final beat of LAST goes to IDLE and raises `done` on the next cycle.
- FIRST routing:
  - `loop[k][0]` = {in[k][2], in[k][0]}; `loop[k][1]` = {in[k][3], in[k][1]}.
  - `address_loop` = `address_in`.
- INTRA routing, per core pair (2j, 2j+1), with q = bit log_t of `address_in[0]`:
  - Ae = {in[2j+1][0], in[2j][0]} / {in[2j+1][1], in[2j][1]}.
  - Ao = {in[2j+1][2], in[2j][2]} / {in[2j+1][3], in[2j][3]}.
  - q = 0: loop[2j] ← Ae, loop[2j+1] ← Ao.
  - q = 1: loop[2j] ← Ao, loop[2j+1] ← Ae.
  - `address_loop[0]` = address_in[0] with bit log_t cleared; `address_loop[1]` = the same with that bit set.
- INTER routing, with jj = log_t − T_INTRA − 1 and d = 2^jj:
  - Bit jj of k = 0: loop[k] ← {in[k+d][0], in[k][0]} / {in[k+d][1], in[k][1]}.
  - Bit jj of k = 1: loop[k] ← {in[k][2], in[k−d][2]} / {in[k][3], in[k−d][3]}.
  - `address_loop` = `address_in`.
- LAST routing:
  - `out[k][0]` = {in[k][1], in[k][0]}; `out[k][1]` = {in[k][3], in[k][2]}.
  - `address_out` = `address_in[0]`.
  - `loop` holds its previous value.
- Beats with `in_valid`=0 are not counted. Data registers hold; valids go low.
- `start` while busy is ignored. `in_valid` while IDLE is ignored, and no valid is raised.
- `start` and `in_valid` in the same idle cycle: the FSM enters FIRST, and that beat is not accepted.

## Timing
- Latency: one cycle from accepted beat to `loop_valid`/`out_valid` with its data.
- `loop_valid` = 1 for beats accepted in FIRST, INTRA or INTER. `out_valid` = 1 for beats accepted in LAST. They are never high together.
- `busy` rises the cycle after `start` and falls in the cycle `done` pulses.
- Sustained `in_valid` makes a transform LOG_N·BEATS beats long; `done` follows the last `out_valid` in the same cycle.
- Reset (asynchronous assert, any time including mid-transform):
  - FSM to IDLE; s and b to 0.
  - All outputs to 0, including data, addresses, valids, `busy` and `done`.
- Reset deassertion is synchronised externally. The first `start` is accepted on the first edge after release.

## Structure
- Package `ntt_pkg` holds:
  - The phase enum {IDLE, FIRST, INTRA, INTER, LAST}.
  - Functions `beats_per_stage(LOG_N, LOG_CORE_COUNT)` and `t_intra(...)`.
  - The packed pair type helper.
- Sub-module `intt_stage_ctrl` holds the FSM, the s and b counters, and `busy`/`done`. It exports phase, log_t and an accept strobe.
- The top holds the routing mux and the output registers.

## Test plan
Unless stated otherwise, tests use LOG_N=6, LOG_CORE_COUNT=1, COEFF_W=30, so BEATS=8, INTRA covers s=1..3, INTER s=4 (d=1), LAST s=5.

- Reset/idle:
  - Stimulus: hold `rst_n`=0, then release and drive `in_valid`=1 with no `start`.
  - Required response: all outputs 0; no valid for 10 cycles.
- FIRST:
  - Stimulus: `start`, then one beat with in[0] = {3,2,1,0} as lanes [3..0] and `address_in`={5,4}.
  - Required response: next cycle `loop[0][0]`={2,0}, `loop[0][1]`={3,1}, `address_loop`={5,4}, `loop_valid`=1.
- INTRA swap:
  - Stimulus: at s=2, `address_in[0]`=4 (q=1).
  - Required response: loop[0] gets Ao, loop[1] gets Ae, `address_loop`={4,0}.
  - Repeat with `address_in[0]`=0 and check loop[0]=Ae.
- INTER and LAST:
  - INTER: check loop[1] = {in[1][2], in[0][2]}.
  - LAST: check `out[0][0]`={in[0][1], in[0][0]} with `out_valid`=1 and `loop` unchanged.
- Full run with gaps:
  - Stimulus: 48 beats with `in_valid` toggling 1/0.
  - Required response: exactly 40 `loop_valid` and 8 `out_valid` pulses; `done` one cycle after the 48th beat; `start` pulsed mid-run is ignored.
- Mid-run reset:
  - Stimulus: assert `rst_n`=0 at beat 20 while `in_valid` is held.
  - Required response: outputs 0 immediately; after release, a new `start` runs a full 48-beat transform.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and sizing helpers for the INTT stage router.
// Phase enum, per-stage beat math and the coefficient pair width.
package ntt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    INTRA,
    INTER,
    LAST
  } phase_t;

  function automatic int t_intra(
    input int log_n,
    input int log_cc
  );
    return log_n - log_cc - 2;
  endfunction

  function automatic int beats_per_stage(
    input int log_n,
    input int log_cc
  );
    return 1 << t_intra(log_n, log_cc);
  endfunction

  function automatic int pair_w(input int coeff_w);
    return 2 * coeff_w;
  endfunction

endpackage

// File: rtl/intt_stage_router_if.sv
// Butterfly-side input beat and memory-side loop/out beats.
// master: drives in_valid/address_in/in; slave: the router.
interface intt_stage_router_if
  import ntt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = 5,
  parameter int COEFF_W        = 30,
  parameter int ADDR_W         = 9
);
  localparam int C  = 1 << LOG_CORE_COUNT;
  localparam int PW = pair_w(COEFF_W);

  logic                             in_valid;
  logic [1:0][ADDR_W-1:0]           address_in;
  logic [C-1:0][3:0][COEFF_W-1:0]   in;

  logic [C-1:0][1:0][PW-1:0]        loop;
  logic [1:0][ADDR_W-1:0]           address_loop;
  logic                             loop_valid;

  logic [C-1:0][1:0][PW-1:0]        out;
  logic [ADDR_W-1:0]                address_out;
  logic                             out_valid;

  modport master (
    output in_valid, address_in, in,
    input  loop, address_loop, loop_valid,
    input  out, address_out, out_valid
  );

  modport slave (
    input  in_valid, address_in, in,
    output loop, address_loop, loop_valid,
    output out, address_out, out_valid
  );

endinterface

// File: rtl/intt_stage_ctrl.sv
// Stage sequencer: stage s (log_t), beat b, phase, busy, done.
// accept marks a beat taken this cycle (in_valid while not IDLE).
module intt_stage_ctrl
  import ntt_pkg::*;
#(
  parameter int LOG_N          = 12,
  parameter int LOG_CORE_COUNT = 5,
  parameter int S_W            = $clog2(LOG_N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  output phase_t         phase,
  output logic [S_W-1:0] log_t,
  output logic           accept,
  output logic           busy,
  output logic           done
);

  localparam int TI    = t_intra(LOG_N, LOG_CORE_COUNT);
  localparam int BEATS = beats_per_stage(LOG_N, LOG_CORE_COUNT);
  localparam int B_W   = TI;

  localparam logic [B_W-1:0] B_LAST = B_W'(BEATS - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(LOG_N - 1);

  logic [B_W-1:0] b;

  function automatic phase_t phase_of(
    input logic [S_W-1:0] s
  );
    if (s == '0)
      return FIRST;
    else if (int'(s) <= TI)
      return INTRA;
    else if (int'(s) <= LOG_N - 2)
      return INTER;
    else
      return LAST;
  endfunction

  assign accept = in_valid && (phase != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= IDLE;
      log_t <= '0;
      b     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (phase)
        IDLE: begin
          if (start) begin
            phase <= FIRST;
            log_t <= '0;
            b     <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          if (in_valid) begin
            if (b == B_LAST) begin
              b <= '0;
              if (log_t == S_LAST) begin
                phase <= IDLE;
                log_t <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                log_t <= log_t + 1'b1;
                phase <= phase_of(log_t + 1'b1);
              end
            end else begin
              b <= b + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/intt_stage_router.sv
// INTT coefficient router: per-phase lane mux, one-cycle registers.
// Ports: clk, rst_n, start, bus (slave), busy, done.
module intt_stage_router
  import ntt_pkg::*;
#(
  parameter int LOG_N          = 12,
  parameter int LOG_CORE_COUNT = 5,
  parameter int COEFF_W        = 30,
  parameter int ADDR_W         = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  intt_stage_router_if.slave  bus,
  output logic                busy,
  output logic                done
);

  localparam int C    = 1 << LOG_CORE_COUNT;
  localparam int PW   = pair_w(COEFF_W);
  localparam int TI   = t_intra(LOG_N, LOG_CORE_COUNT);
  localparam int S_W  = $clog2(LOG_N);
  localparam int CI_W = (LOG_CORE_COUNT > 0) ? LOG_CORE_COUNT : 1;

  typedef logic [C-1:0][1:0][PW-1:0] bank_t;
  typedef logic [1:0][ADDR_W-1:0]    apair_t;

  phase_t         phase;
  logic [S_W-1:0] log_t;
  logic           accept;

  intt_stage_ctrl #(
    .LOG_N          (LOG_N),
    .LOG_CORE_COUNT (LOG_CORE_COUNT),
    .S_W            (S_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (bus.in_valid),
    .phase    (phase),
    .log_t    (log_t),
    .accept   (accept),
    .busy     (busy),
    .done     (done)
  );

  bank_t             loop_q;
  bank_t             out_q;
  apair_t            aloop_q;
  logic [ADDR_W-1:0] aout_q;
  logic              loop_valid_q;
  logic              out_valid_q;

  bank_t             loop_d;
  bank_t             out_d;
  apair_t            aloop_d;
  logic [ADDR_W-1:0] mask;
  logic              q;
  int                jj;
  logic [CI_W-1:0]   dmask;
  logic [CI_W-1:0]   p;

  always_comb begin
    loop_d  = loop_q;
    aloop_d = bus.address_in;
    mask    = ADDR_W'(1) << log_t;
    q       = |(bus.address_in[0] & mask);
    jj      = int'(log_t) - TI - 1;
    dmask   = '0;
    p       = '0;
    unique case (phase)
      FIRST: begin
        for (int k = 0; k < C; k++) begin
          loop_d[k][0] = {bus.in[k][2], bus.in[k][0]};
          loop_d[k][1] = {bus.in[k][3], bus.in[k][1]};
        end
      end
      INTRA: begin
        // q picks which core of the pair gets the even/odd halves
        for (int j = 0; j < C / 2; j++) begin
          if (q) begin
            loop_d[2*j][0]   = {bus.in[2*j+1][2], bus.in[2*j][2]};
            loop_d[2*j][1]   = {bus.in[2*j+1][3], bus.in[2*j][3]};
            loop_d[2*j+1][0] = {bus.in[2*j+1][0], bus.in[2*j][0]};
            loop_d[2*j+1][1] = {bus.in[2*j+1][1], bus.in[2*j][1]};
          end else begin
            loop_d[2*j][0]   = {bus.in[2*j+1][0], bus.in[2*j][0]};
            loop_d[2*j][1]   = {bus.in[2*j+1][1], bus.in[2*j][1]};
            loop_d[2*j+1][0] = {bus.in[2*j+1][2], bus.in[2*j][2]};
            loop_d[2*j+1][1] = {bus.in[2*j+1][3], bus.in[2*j][3]};
          end
        end
        aloop_d[0] = bus.address_in[0] & ~mask;
        aloop_d[1] = bus.address_in[0] | mask;
      end
      INTER: begin
        // partner k^d is k+d when bit jj of k is 0, else k-d
        dmask = CI_W'(1) << jj;
        for (int k = 0; k < C; k++) begin
          p = CI_W'(k) ^ dmask;
          if ((CI_W'(k) & dmask) == '0) begin
            loop_d[k][0] = {bus.in[p][0], bus.in[k][0]};
            loop_d[k][1] = {bus.in[p][1], bus.in[k][1]};
          end else begin
            loop_d[k][0] = {bus.in[k][2], bus.in[p][2]};
            loop_d[k][1] = {bus.in[k][3], bus.in[p][3]};
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_d = '0;
    for (int k = 0; k < C; k++) begin
      out_d[k][0] = {bus.in[k][1], bus.in[k][0]};
      out_d[k][1] = {bus.in[k][3], bus.in[k][2]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q       <= '0;
      aloop_q      <= '0;
      loop_valid_q <= 1'b0;
      out_q        <= '0;
      aout_q       <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      loop_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      if (accept) begin
        if (phase == LAST) begin
          out_q       <= out_d;
          aout_q      <= bus.address_in[0];
          out_valid_q <= 1'b1;
        end else begin
          loop_q       <= loop_d;
          aloop_q      <= aloop_d;
          loop_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.loop         = loop_q;
  assign bus.address_loop = aloop_q;
  assign bus.loop_valid   = loop_valid_q;
  assign bus.out          = out_q;
  assign bus.address_out  = aout_q;
  assign bus.out_valid    = out_valid_q;

endmodule

// File: tb/tb_intt_stage_router.sv
// Directed bench for intt_stage_router, LOG_N=6, C=2.
// Hand-computed routing vectors, beat counts and reset checks.
module tb_intt_stage_router;

  localparam int LOG_N = 6;
  localparam int LCC   = 1;
  localparam int CW    = 30;
  localparam int AW    = 9;
  localparam int C     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;
  int nl, no, nd, dat;

  always #5 clk = ~clk;

  intt_stage_router_if #(
    .LOG_CORE_COUNT (LCC),
    .COEFF_W        (CW),
    .ADDR_W         (AW)
  ) bus ();

  intt_stage_router #(
    .LOG_N          (LOG_N),
    .LOG_CORE_COUNT (LCC),
    .COEFF_W        (CW),
    .ADDR_W         (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  function automatic logic [63:0] pr(int hi, int lo);
    return {4'b0, CW'(hi), CW'(lo)};
  endfunction

  function automatic logic [63:0] ad(int a1, int a0);
    return {46'b0, AW'(a1), AW'(a0)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int base, int a1, int a0);
    for (int k = 0; k < C; k++)
      for (int l = 0; l < 4; l++)
        bus.in[k][l] = CW'(base + 4 * k + l);
    bus.address_in[1] = AW'(a1);
    bus.address_in[0] = AW'(a0);
  endtask

  task automatic fill(int n);
    bus.in_valid = 1'b1;
    set_in(1000, 1, 2);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_loop"}, 64'(|bus.loop), 0);
    chk({tag, "_out"}, 64'(|bus.out), 0);
    chk({tag, "_addr"},
        {bus.address_loop, bus.address_out}, 0);
    chk({tag, "_flags"},
        {bus.loop_valid, bus.out_valid, busy, done}, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    set_in(0, 0, 0);

    // reset and idle
    repeat (3) step();
    chk_zero("rst");
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    set_in(50, 3, 4);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_nv",
          {bus.loop_valid, bus.out_valid, busy, done}, 0);
    end

    // FIRST
    bus.in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_up", 64'(busy), 1);
    set_in(0, 5, 4);
    for (int l = 0; l < 4; l++) bus.in[1][l] = CW'(10 + l);
    bus.in_valid = 1'b1;
    step();
    chk("first_l00", bus.loop[0][0], pr(2, 0));
    chk("first_l01", bus.loop[0][1], pr(3, 1));
    chk("first_l10", bus.loop[1][0], pr(12, 10));
    chk("first_addr", bus.address_loop, ad(5, 4));
    chk("first_v", {bus.loop_valid, bus.out_valid}, 2'b10);
    fill(15);

    // INTRA s=2, q=1 swaps
    set_in(100, 7, 4);
    step();
    chk("intra1_l00", bus.loop[0][0], pr(106, 102));
    chk("intra1_l01", bus.loop[0][1], pr(107, 103));
    chk("intra1_l10", bus.loop[1][0], pr(104, 100));
    chk("intra1_addr", bus.address_loop, ad(4, 0));
    // q=0
    set_in(200, 7, 0);
    step();
    chk("intra0_l00", bus.loop[0][0], pr(204, 200));
    chk("intra0_l11", bus.loop[1][1], pr(207, 203));
    chk("intra0_addr", bus.address_loop, ad(4, 0));
    // gap holds data, drops valid
    bus.in_valid = 1'b0;
    set_in(900, 0, 0);
    step();
    chk("gap_v", {bus.loop_valid, bus.out_valid}, 0);
    chk("gap_hold", bus.loop[0][0], pr(204, 200));
    fill(14);

    // INTER s=4, d=1
    set_in(300, 9, 8);
    step();
    chk("inter_l00", bus.loop[0][0], pr(304, 300));
    chk("inter_l01", bus.loop[0][1], pr(305, 301));
    chk("inter_l10", bus.loop[1][0], pr(306, 302));
    chk("inter_l11", bus.loop[1][1], pr(307, 303));
    chk("inter_addr", bus.address_loop, ad(9, 8));
    fill(6);
    set_in(500, 1, 1);
    step();
    chk("inter_last", bus.loop[0][0], pr(504, 500));

    // LAST
    set_in(400, 3, 17);
    step();
    chk("last_o00", bus.out[0][0], pr(401, 400));
    chk("last_o01", bus.out[0][1], pr(403, 402));
    chk("last_o10", bus.out[1][0], pr(405, 404));
    chk("last_addr", 64'(bus.address_out), 17);
    chk("last_v", {bus.loop_valid, bus.out_valid}, 2'b01);
    chk("last_hold", bus.loop[0][0], pr(504, 500));
    fill(6);
    chk("pre_done", {busy, done}, 2'b10);
    set_in(600, 0, 0);
    step();
    chk("done_pulse", {bus.out_valid, busy, done}, 3'b101);
    bus.in_valid = 1'b0;
    step();
    chk("done_low", {bus.out_valid, busy, done}, 0);

    // full run with gaps and a stray start
    start = 1'b1;
    step();
    start = 1'b0;
    nl = 0; no = 0; nd = 0; dat = -1;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = (i % 2 == 0);
      start = (i == 41);
      set_in(i * 8, i, i);
      step();
      nl += int'(bus.loop_valid);
      no += int'(bus.out_valid);
      if (bus.loop_valid && bus.out_valid)
        nd += 100;
      if (done) begin
        nd++;
        dat = i;
      end
    end
    start = 1'b0;
    chk("gap_nloop", 64'(nl), 40);
    chk("gap_nout", 64'(no), 8);
    chk("gap_ndone", 64'(nd), 1);
    chk("gap_done_at", 64'(dat), 94);
    chk("gap_idle", 64'(busy), 0);

    // mid-run reset
    bus.in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(i * 4 + 1, 2, 3);
      step();
    end
    chk("mid_v", 64'(bus.loop_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    step();
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun_busy", 64'(busy), 1);
    nl = 0; no = 0; nd = 0; dat = -1;
    for (int i = 0; i < 51; i++) begin
      bus.in_valid = (i < 48);
      set_in(i + 7, 1, i);
      step();
      nl += int'(bus.loop_valid);
      no += int'(bus.out_valid);
      if (done) begin
        nd++;
        dat = i;
      end
    end
    chk("rerun_nloop", 64'(nl), 40);
    chk("rerun_nout", 64'(no), 8);
    chk("rerun_ndone", 64'(nd), 1);
    chk("rerun_done_at", 64'(dat), 47);
    chk("rerun_idle", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
